// File: rtl/store_merge_unit.sv
// rtl/store_merge_unit.sv - byte/halfword/word store with read-modify-write on a word memory
//
// Purpose: accepts an SB/SH/SW store request, reads the containing word when
// only part of it changes, merges the new lane in (big-endian lanes), and
// writes the word back. A start/busy/done handshake stalls the pipeline
// while the request completes.
//
// Optional feature macro: STORE_ALIGN_CHECK_EN
//   defined   - misaligned SH (direccion[0]=1) and SW (direccion[1:0]!=0)
//               are rejected with done+error and no memory access
//   undefined - the offending low address bits are ignored
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-high reset, forces IDLE
//   start      request strobe, sampled only in IDLE
//   opcode     3'b000 SB, 3'b001 SH, 3'b011 SW, others illegal
//   entrada    store data
//   direccion  byte address
//   mem_addr   word address to memory (0 in IDLE)
//   mem_re     memory read enable (1-cycle read latency)
//   mem_dout   memory read data
//   mem_we     memory write enable
//   mem_din    memory write data (0 when mem_we=0)
//   busy       high whenever not IDLE
//   done       one-cycle completion pulse
//   error      one-cycle rejection pulse, coincident with done

module store_merge_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  opcode,
    input  logic [31:0] entrada,
    input  logic [11:0] direccion,
    output logic [9:0]  mem_addr,
    output logic        mem_re,
    input  logic [31:0] mem_dout,
    output logic        mem_we,
    output logic [31:0] mem_din,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam logic [2:0] OP_SB = 3'b000;
    localparam logic [2:0] OP_SH = 3'b001;
    localparam logic [2:0] OP_SW = 3'b011;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WR   = 3'd2,
        S_DN   = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [2:0]  op_q;
    logic [31:0] data_q;
    logic [11:0] addr_q;

    logic        in_sb;
    logic        in_sh;
    logic        in_sw;
    logic        misaligned;
    logic        req_bad;
    logic [31:0] merged;

    assign in_sb = (opcode == OP_SB);
    assign in_sh = (opcode == OP_SH);
    assign in_sw = (opcode == OP_SW);

`ifdef STORE_ALIGN_CHECK_EN
    assign misaligned = (in_sh && direccion[0]) ||
                        (in_sw && (direccion[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    assign req_bad = !(in_sb || in_sh || in_sw) || misaligned;

    // State register plus request latch; the latch only loads on acceptance
    // so later input changes cannot disturb an operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            op_q   <= 3'b000;
            data_q <= 32'h0;
            addr_q <= 12'h0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && start) begin
                op_q   <= opcode;
                data_q <= entrada;
                addr_q <= direccion;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (req_bad)
                        state_nxt = S_ERR;
                    else if (in_sw)
                        state_nxt = S_WR;
                    else
                        state_nxt = S_RD;
                end
            end
            S_RD:    state_nxt = S_WR;
            S_WR:    state_nxt = S_DN;
            S_DN:    state_nxt = S_IDLE;
            S_ERR:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Lane replacement on the word returned by the read in RD. Offset 0 is
    // the most significant byte (big-endian).
    always_comb begin
        merged = mem_dout;
        if (op_q == OP_SB) begin
            case (addr_q[1:0])
                2'd0:    merged = {data_q[7:0], mem_dout[23:0]};
                2'd1:    merged = {mem_dout[31:24], data_q[7:0], mem_dout[15:0]};
                2'd2:    merged = {mem_dout[31:16], data_q[7:0], mem_dout[7:0]};
                default: merged = {mem_dout[31:8], data_q[7:0]};
            endcase
        end else if (op_q == OP_SH) begin
            if (addr_q[1])
                merged = {mem_dout[31:16], data_q[15:0]};
            else
                merged = {data_q[15:0], mem_dout[15:0]};
        end
    end

    // Outputs decode purely from state, so an asynchronous reset clears
    // them in the same cycle.
    always_comb begin
        mem_addr = 10'h0;
        mem_re   = 1'b0;
        mem_we   = 1'b0;
        mem_din  = 32'h0;
        busy     = 1'b0;
        done     = 1'b0;
        error    = 1'b0;
        case (state)
            S_RD: begin
                busy     = 1'b1;
                mem_addr = addr_q[11:2];
                mem_re   = 1'b1;
            end
            S_WR: begin
                busy     = 1'b1;
                mem_addr = addr_q[11:2];
                mem_we   = 1'b1;
                mem_din  = (op_q == OP_SW) ? data_q : merged;
            end
            S_DN: begin
                busy     = 1'b1;
                mem_addr = addr_q[11:2];
                done     = 1'b1;
            end
            S_ERR: begin
                busy     = 1'b1;
                mem_addr = addr_q[11:2];
                done     = 1'b1;
                error    = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: doc/store_merge_unit.md
# store_merge_unit

Store-side counterpart of the load truncation unit in the pipeline's MEM stage. Takes a store request (SB/SH/SW) with register data and a 12-bit byte address. Performs a read-modify-write on the word-wide data memory so that only the addressed byte or halfword changes. Uses a start/busy/done handshake, so the pipeline stalls while a partial store completes.

## Interface
- No parameters.
- `clk`  in  1  single system clock; all state on rising edge
- `reset`  in  1  asynchronous, active-high; forces IDLE
- `start`  in  1  request strobe; sampled only in IDLE
- `opcode`  in  3  store size: 3'b000 SB, 3'b001 SH, 3'b011 SW; all others illegal
- `entrada`  in  32  store data from register file; low byte/half used for SB/SH
- `direccion`  in  12  byte address
- `mem_addr`  out  10  word address = latched direccion[11:2]
- `mem_re`  out  1  memory read enable (synchronous read, 1-cycle latency)
- `mem_dout`  in  32  read data from memory, valid the cycle after mem_re
- `mem_we`  out  1  memory write enable
- `mem_din`  out  32  word written to memory
- `busy`  out  1  high whenever state != IDLE
- `done`  out  1  one-cycle completion pulse
- `error`  out  1  one-cycle pulse, coincident with done, on rejected request

## Operation
- States: IDLE, RD, WR, DN, ERR.
- IDLE: if `start`=1, latch opcode, entrada and direccion.
  - Illegal opcode, or misaligned (see Configuration) -> ERR.
  - SW -> WR.
  - SB/SH -> RD.
- RD: `mem_re`=1, `mem_addr` driven -> WR.
- WR: `mem_we`=1 for exactly one cycle -> DN.
  - SW: `mem_din` = latched entrada.
  - SB/SH: `mem_din` = `mem_dout` with the target lane replaced (combinational from `mem_dout`).
- DN: `done`=1 -> IDLE.
- ERR: `done`=1, `error`=1, no memory access -> IDLE.
- Byte order is big-endian. Offset direccion[1:0]=0 is bits 31:24, 1 is 23:16, 2 is 15:8, 3 is 7:0.
  - SB writes entrada[7:0] into the selected byte.
  - SH with direccion[1]=0 writes entrada[15:0] into bits 31:16; direccion[1]=1 writes bits 15:0.
- `mem_addr` holds the latched word address in all non-IDLE states. It is 0 in IDLE.
- `mem_din` is 0 when `mem_we`=0.
- `start` is ignored while busy. Input changes after the latch cycle have no effect.

## Timing
- Reset values: state IDLE; mem_addr, mem_re, mem_we, mem_din, busy, done, error all 0.
- `reset` asserted mid-operation (any state) drops all outputs to 0 immediately, asynchronously.
  - A write not yet issued is lost. Memory is never partially written.
- `start` sampled at edge k. Then:
  - SB/SH: RD in cycle k+1, WR in k+2, `done` in k+3. Busy for 3 cycles.
  - SW: WR in k+1, `done` in k+2. `mem_re` never asserted.
  - ERR: `done`+`error` in k+1.
- `start` asserted in the DN cycle is ignored. A new request may be sampled in the first IDLE cycle after `done`.
- The back-to-back minimum period is 4 cycles for SB/SH and 3 cycles for SW.

## Configuration
- `STORE_ALIGN_CHECK_EN` defined:
  - SH with direccion[0]=1 is misaligned and goes to ERR with no write.
  - SW with direccion[1:0]!=0 is misaligned and goes to ERR with no write.
- `STORE_ALIGN_CHECK_EN` undefined:
  - The offending low bits are ignored: SH uses direccion[1], SW uses the word address.
  - `error` asserts only for illegal opcodes.

## Test plan
- Memory word 0x004 = 0x11223344. SB, entrada=0xFFFFFFAB, direccion=0x011 -> mem_re at k+1, mem_we at k+2 with mem_din=0x11AB3344, done at k+3, error=0.
- Same word. SH, entrada=0x0000BEEF, direccion=0x012 -> mem_din=0x1122BEEF. SH at 0x010 -> mem_din=0xBEEF3344.
- SW, entrada=0xFFFFFFFF, direccion=0x010 -> no mem_re, mem_we at k+1 with mem_din=0xFFFFFFFF, done at k+2.
- With `STORE_ALIGN_CHECK_EN`: SH at direccion=0x013 -> done=error=1 at k+1, mem_we never asserted.
  - Without the macro: same request writes bits 15:0.
- opcode=3'b010 -> error pulse at k+1, no memory access.
- `reset` raised during RD of an SB -> all outputs 0 in the same cycle, memory word unchanged.
  - `start` held high through a busy SB -> exactly one write and one done, and a second request is accepted only after return to IDLE.
